// File: rtl/attack_resolver_pkg.sv
// Shared definitions for the attack resolver: FSM encoding, LFSR taps/seed
// and the default HP ceiling also used by the HP display logic.
package attack_resolver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Feedback taps for x^4 + x^3 + 1 (bits 3 and 2 of the shift register).
  localparam logic [3:0] LFSR_TAPS         = 4'b1100;
  localparam logic [3:0] LFSR_SEED_DEFAULT = 4'b1001;
  localparam int         HP_MAX_DEFAULT    = 50;

  function automatic logic [3:0] lfsr4_next(input logic [3:0] value);
    return {value[2:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/attack_resolver_lfsr4.sv
// Free-running 4-bit Fibonacci LFSR; a non-zero seed keeps it in the 1..15 cycle.
// Shared by the attack resolver and the CPU opponent's move selection.
module lfsr4
  import attack_resolver_pkg::*;
#(
  parameter logic [3:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] o_value
);

  logic [3:0] r_lfsr;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= lfsr4_next(r_lfsr);
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/attack_resolver.sv
// Resolves one attack: rolls the LFSR against accuracy, then drains the
// defender's HP one point per clock so the display can animate the loss.
module attack_resolver
  import attack_resolver_pkg::*;
#(
  parameter int         HP_W      = 6,
  parameter int         HP_MAX    = HP_MAX_DEFAULT,
  parameter logic [3:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      dmg,
  input  logic [3:0]      accu,
  input  logic            hp_load,
  output logic [HP_W-1:0] hp,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic            fainted
);

  localparam logic [HP_W-1:0] HP_MAX_V = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0] HP_ONE   = HP_W'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [3:0]      w_lfsr;
  logic            w_hit_now;
  logic [HP_W-1:0] r_hp;
  logic [3:0]      r_dmg_q;
  logic [3:0]      r_accu_q;
  logic [3:0]      r_roll_q;
  logic [3:0]      r_remaining;
  logic            r_busy;
  logic            r_done;
  logic            r_hit;
  logic            r_fainted;

  lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_value (w_lfsr)
  );

  assign w_hit_now = (r_roll_q <= r_accu_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment ahead of the case keeps every path driven,
  // so no latch is inferred for the next-state signal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (!hp_load && start && !r_fainted) w_next_state = ST_ROLL;
      ST_ROLL:  w_next_state = (w_hit_now && r_dmg_q != 4'd0) ? ST_DRAIN : ST_DONE;
      // Exit on the edge that removes the last point of damage or of HP.
      ST_DRAIN: if (r_remaining <= 4'd1 || r_hp <= HP_ONE) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hp        <= HP_MAX_V;
      r_dmg_q     <= 4'd0;
      r_accu_q    <= 4'd0;
      r_roll_q    <= 4'd0;
      r_remaining <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
      r_fainted   <= 1'b0;
    end else begin
      // busy spans the whole attack; done follows the DONE state by one edge.
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (hp_load) begin
            r_hp      <= HP_MAX_V;
            r_fainted <= 1'b0;
          end else if (start && !r_fainted) begin
            r_dmg_q  <= dmg;
            r_accu_q <= accu;
            r_roll_q <= w_lfsr;
          end
        end
        ST_ROLL: begin
          r_hit       <= w_hit_now;
          r_remaining <= w_hit_now ? r_dmg_q : 4'd0;
        end
        ST_DRAIN: begin
          if (r_hp != '0 && r_remaining != 4'd0) begin
            r_hp        <= r_hp - HP_ONE;
            r_remaining <= r_remaining - 4'd1;
            if (r_hp == HP_ONE) r_fainted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hp      = r_hp;
  assign busy    = r_busy;
  assign done    = r_done;
  assign hit     = r_hit;
  assign fainted = r_fainted;

endmodule
